regfile_rd: RTL and testbench

Architectural register file on the read side of the write-back path. Accepts the retiring result, destination index and write-enable from the write-back stage, stores it in 31 general-purpose registers (x0 hardwired to zero), and serves two same-cycle read ports to the decode stage with write-first bypass. Also counts retired instructions from the write-back valid flag and exposes a debug read port for the test bench and for the debug unit.

---
 rtl/regfile_rd_pkg.sv | 12 +
 rtl/regfile_rd_if.sv | 32 +++
 rtl/rf_bypass_rd.sv | 23 ++
 rtl/regfile_rd.sv | 81 ++++++++
 tb/tb_regfile_rd.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_rd_pkg.sv
// Shared pipeline definitions for the architectural register file:
// index width, data width, the x0 constant and the register index type.
package regfile_rd_pkg;

   localparam int REG_IDX_W = 5;
   localparam int DATA_W    = 32;

   typedef logic [REG_IDX_W-1:0] regidx_t;

   localparam regidx_t X0 = '0;

endpackage

// File: rtl/regfile_rd_if.sv
// Write-back / decode / debug bundle between the pipeline (master) and the register file (slave).
interface regfile_rd_if #(
   parameter int DATA_W = regfile_rd_pkg::DATA_W,
   parameter int CNT_W  = 64
);
   import regfile_rd_pkg::*;

   // No ready path: a write is taken on the edge whenever RegWriteW and insn_vld are both high,
   // and insn_vld alone marks a retiring instruction; reads are combinational with no handshake.
   logic              RegWriteW;
   regidx_t           RdW;
   logic [DATA_W-1:0] ResultW;
   logic              insn_vld;
   regidx_t           Rs1D;
   regidx_t           Rs2D;
   logic [DATA_W-1:0] RD1D;
   logic [DATA_W-1:0] RD2D;
   regidx_t           dbg_addr;
   logic [DATA_W-1:0] dbg_data;
   logic [CNT_W-1:0]  instret;

   modport master (
      output RegWriteW, RdW, ResultW, insn_vld, Rs1D, Rs2D, dbg_addr,
      input  RD1D, RD2D, dbg_data, instret
   );

   modport slave (
      input  RegWriteW, RdW, ResultW, insn_vld, Rs1D, Rs2D, dbg_addr,
      output RD1D, RD2D, dbg_data, instret
   );

endinterface

// File: rtl/rf_bypass_rd.sv
// One register-file read port: x0 forces zero, a same-cycle qualified write to the
// same index is forwarded ahead of the stored value.
module rf_bypass_rd import regfile_rd_pkg::*; #(
   parameter int WIDTH = 32
) (
   input  regidx_t            i_rd_idx,
   input  logic               i_wr_en,
   input  regidx_t            i_wr_idx,
   input  logic [WIDTH-1:0]   i_wr_data,
   input  logic [WIDTH-1:0]   i_mem_data,
   output logic [WIDTH-1:0]   o_rd_data
);

   always_comb begin
      o_rd_data = i_mem_data;
      if (i_rd_idx == X0) begin
         o_rd_data = '0;
      end else if (i_wr_en && (i_wr_idx == i_rd_idx)) begin
         o_rd_data = i_wr_data;
      end
   end

endmodule

// File: rtl/regfile_rd.sv
// Architectural register file: 31 writable registers plus hardwired x0, two bypassed
// decode read ports, a registered debug read port and a retired-instruction counter.
module regfile_rd #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32,
   parameter int CNT_W  = 64
) (
   input  logic        clk,
   input  logic        rst,
   regfile_rd_if.slave rf_bus
);
   import regfile_rd_pkg::*;

   logic [DATA_W-1:0] r_mem [NREG];
   logic [DATA_W-1:0] r_dbg_data;
   logic [CNT_W-1:0]  r_instret;

   logic              w_wr_qual;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   logic [DATA_W-1:0] w_dbg;

   // Reset kills both the write and the bypass, so the read ports show stored data only.
   assign w_wr_qual = rf_bus.RegWriteW & rf_bus.insn_vld & ~rst;

   rf_bypass_rd #(.WIDTH(DATA_W)) u_port_a (
      .i_rd_idx   (rf_bus.Rs1D),
      .i_wr_en    (w_wr_qual),
      .i_wr_idx   (rf_bus.RdW),
      .i_wr_data  (rf_bus.ResultW),
      .i_mem_data (r_mem[rf_bus.Rs1D]),
      .o_rd_data  (w_rd1)
   );

   rf_bypass_rd #(.WIDTH(DATA_W)) u_port_b (
      .i_rd_idx   (rf_bus.Rs2D),
      .i_wr_en    (w_wr_qual),
      .i_wr_idx   (rf_bus.RdW),
      .i_wr_data  (rf_bus.ResultW),
      .i_mem_data (r_mem[rf_bus.Rs2D]),
      .o_rd_data  (w_rd2)
   );

   rf_bypass_rd #(.WIDTH(DATA_W)) u_port_dbg (
      .i_rd_idx   (rf_bus.dbg_addr),
      .i_wr_en    (w_wr_qual),
      .i_wr_idx   (rf_bus.RdW),
      .i_wr_data  (rf_bus.ResultW),
      .i_mem_data (r_mem[rf_bus.dbg_addr]),
      .o_rd_data  (w_dbg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_qual && (rf_bus.RdW != X0)) begin
         r_mem[rf_bus.RdW] <= rf_bus.ResultW;
      end
   end

   // Every retiring instruction counts, whether or not it writes a register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_instret  <= '0;
         r_dbg_data <= '0;
      end else begin
         r_dbg_data <= w_dbg;
         if (rf_bus.insn_vld) begin
            r_instret <= r_instret + CNT_W'(1);
         end
      end
   end

   assign rf_bus.RD1D     = w_rd1;
   assign rf_bus.RD2D     = w_rd2;
   assign rf_bus.dbg_data = r_dbg_data;
   assign rf_bus.instret  = r_instret;

endmodule

// File: tb/tb_regfile_rd.sv
// Randomised scoreboard bench for regfile_rd: a per-cycle expectation queue filled by the
// driver from a register-array reference model, drained by an independent monitor.
module tb_regfile_rd;

   localparam int DW = 32;
   localparam int CW = 64;

   typedef struct {
      logic [DW-1:0] rd1;
      logic [DW-1:0] rd2;
      logic [DW-1:0] dbg;
      logic [CW-1:0] cnt;
      bit            chk_rd;
      bit            chk_cnt;
      string         tag;
   } exp_t;

   logic clk;
   logic rst;

   regfile_rd_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

   regfile_rd #(.DATA_W(DW), .NREG(32), .CNT_W(CW)) dut (
      .clk    (clk),
      .rst    (rst),
      .rf_bus (bus)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // reference model
   logic [DW-1:0] ref_mem [32];
   logic [CW-1:0] ref_instret;
   logic [DW-1:0] ref_dbg;
   bit            known   = 1'b0;
   bit            cnt_ok  = 1'b1;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic logic [DW-1:0] ref_read(input logic [4:0] idx, input bit r, input bit we,
                                               input bit vld, input logic [4:0] rd,
                                               input logic [DW-1:0] res);
      if (idx == 5'd0) return '0;
      if (!r && we && vld && (rd != 5'd0) && (rd == idx)) return res;
      return ref_mem[idx];
   endfunction

   // driver: one call = one clock cycle of stimulus
   task automatic cycle(input bit r, input bit we, input bit vld, input logic [4:0] rd,
                        input logic [DW-1:0] res, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] dbga, input string tag);
      exp_t          e;
      logic [DW-1:0] dnext;
      @(negedge clk);
      rst           = r;
      bus.RegWriteW = we;
      bus.insn_vld  = vld;
      bus.RdW       = rd;
      bus.ResultW   = res;
      bus.Rs1D      = rs1;
      bus.Rs2D      = rs2;
      bus.dbg_addr  = dbga;
      e.rd1     = ref_read(rs1, r, we, vld, rd, res);
      e.rd2     = ref_read(rs2, r, we, vld, rd, res);
      e.dbg     = ref_dbg;
      e.cnt     = ref_instret;
      e.chk_rd  = known;
      e.chk_cnt = known && cnt_ok;
      e.tag     = tag;
      exp_q.push_back(e);
      dnext = ref_read(dbga, r, we, vld, rd, res);
      if (r) begin
         foreach (ref_mem[i]) ref_mem[i] = '0;
         ref_instret = '0;
         ref_dbg     = '0;
         known       = 1'b1;
      end else begin
         if (we && vld && (rd != 5'd0)) ref_mem[rd] = res;
         if (vld) ref_instret = ref_instret + 1;
         ref_dbg = dnext;
      end
   endtask

   task automatic idle(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] dbga,
                       input string tag);
      cycle(1'b0, 1'b0, 1'b0, 5'd0, '0, rs1, rs2, dbga, tag);
   endtask

   // scoreboard monitor
   task automatic check(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk_rd) begin
               check({e.tag, " RD1D"}, CW'(bus.RD1D), CW'(e.rd1));
               check({e.tag, " RD2D"}, CW'(bus.RD2D), CW'(e.rd2));
               check({e.tag, " dbg_data"}, CW'(bus.dbg_data), CW'(e.dbg));
            end
            if (e.chk_cnt) check({e.tag, " instret"}, bus.instret, e.cnt);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   // stimulus
   initial begin
      logic [4:0]    rd;
      logic [4:0]    rs1;
      logic [4:0]    rs2;
      rst = 1'b1;
      bus.RegWriteW = 1'b0;
      bus.insn_vld  = 1'b0;
      bus.RdW       = '0;
      bus.ResultW   = '0;
      bus.Rs1D      = '0;
      bus.Rs2D      = '0;
      bus.dbg_addr  = '0;

      cycle(1'b1, 1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 5'd0, "reset0");
      cycle(1'b1, 1'b0, 1'b0, 5'd0, '0, 5'd1, 5'd2, 5'd3, "reset1");
      for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i), 5'(i), "sweep");

      cycle(1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd6, 5'd5, "write_x5");
      idle(5'd5, 5'd6, 5'd5, "read_x5");

      cycle(1'b0, 1'b1, 1'b1, 5'd7, 32'h0000_1234, 5'd7, 5'd7, 5'd7, "bypass_x7");
      idle(5'd7, 5'd5, 5'd0, "after_bypass");

      cycle(1'b0, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, "write_x0");
      idle(5'd0, 5'd0, 5'd0, "read_x0");
      cycle(1'b0, 1'b1, 1'b1, 5'd3, 32'h0000_0033, 5'd2, 5'd2, 5'd2, "write_x3");
      cycle(1'b0, 1'b1, 1'b0, 5'd3, 32'h0000_0BAD, 5'd3, 5'd3, 5'd3, "bubble_x3");
      idle(5'd3, 5'd3, 5'd3, "read_x3");

      for (int i = 0; i < 10; i++)
         cycle(1'b0, (i % 3) != 0, 1'b1, 5'(10 + i), $urandom, 5'(10 + i), 5'd5, 5'(10 + i), "count10");
      idle(5'd10, 5'd11, 5'd12, "count_done");

      // preload the counter just below wrap
      #3;
      force dut.r_instret = '1;
      cnt_ok = 1'b0;
      idle(5'd0, 5'd0, 5'd0, "force_hold");
      #3;
      release dut.r_instret;
      ref_instret = '1;
      cnt_ok = 1'b1;
      cycle(1'b0, 1'b0, 1'b1, 5'd0, '0, 5'd0, 5'd0, 5'd0, "wrap_edge");
      idle(5'd0, 5'd0, 5'd0, "wrapped");

      cycle(1'b0, 1'b1, 1'b1, 5'd9, 32'h1111_2222, 5'd0, 5'd0, 5'd0, "write_x9");
      cycle(1'b1, 1'b1, 1'b1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd9, 5'd9, "rst_mid_write");
      idle(5'd9, 5'd5, 5'd9, "after_rst");

      for (int i = 0; i < 400; i++) begin
         rd  = 5'($urandom_range(0, 31));
         rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
         rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
         cycle($urandom_range(0, 39) == 0, 1'($urandom), $urandom_range(0, 4) != 0, rd, $urandom,
               rs1, rs2, 5'($urandom_range(0, 31)), "random");
      end

      repeat (3) @(negedge clk);
      #5;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
